// File: rtl/i2c_wb_regs.sv
// Wishbone classic register bank for an I2C core: ack and read data one cycle after strobe, writes commit in the ack cycle.
// Optional interrupt logic is built when I2C_WB_IRQ_EN is defined; otherwise IRQ_EN reads 0 and o_irq is tied low.
module i2c_wb_regs #(
    parameter logic [15:0] CLK_DIV_RESET = 16'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic [7:0]  clk_div_lo,
    output logic [7:0]  clk_div_hi,
    output logic [7:0]  tx,
    output logic [7:0]  ctrl,
    input  logic [7:0]  rx,
    input  logic [7:0]  status,
    output logic        o_irq
);
    localparam logic [7:0] CTRL_KEEP  = 8'h93;
    localparam logic [7:0] CTRL_PULSE = 8'h6C;

    logic [2:0] idx;
    logic [7:0] wd;
    logic       req;
    logic       wr;
    logic       wr_status;
    logic [7:0] ctrl_keep;
    logic [7:0] ctrl_pulse;
    logic [7:0] rx_q;
    logic [7:0] rd_val;
    logic [2:0] status_q;
    logic       done_sticky;
    logic       nack_sticky;
    logic       done_rise;
    logic       nack_rise;
    logic       unused_bits;

    assign idx       = i_wb_adr[4:2];
    assign wd        = i_wb_dat[7:0];
    assign req       = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    // Gating with cyc/stb in the ack cycle makes an abandoned transfer side-effect free.
    assign wr        = o_wb_ack & i_wb_cyc & i_wb_stb & i_wb_we & i_wb_sel[0];
    assign wr_status = wr && (idx == 3'd5);
    assign ctrl      = ctrl_keep | ctrl_pulse;
    assign done_rise = status[1] & ~status_q[1];
    assign nack_rise = status[2] & ~status_q[2];

    assign unused_bits = &{1'b0, i_wb_adr[5], i_wb_adr[1:0], i_wb_dat[31:8],
                           i_wb_sel[3:1], status[7:3]};

`ifdef I2C_WB_IRQ_EN
    logic [7:0] irq_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 8'h00;
            o_irq  <= 1'b0;
        end else begin
            if (wr && (idx == 3'd6))
                irq_en <= wd;
            o_irq <= (done_sticky & irq_en[0]) | (nack_sticky & irq_en[1]);
        end
    end
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        rd_val = 8'h00;
        case (idx)
            3'd0: rd_val = clk_div_lo;
            3'd1: rd_val = clk_div_hi;
            3'd2: rd_val = tx;
            3'd3: rd_val = rx_q;
            3'd4: rd_val = ctrl_keep;
            3'd5: rd_val = {3'b000, nack_sticky, done_sticky, status[2:0]};
`ifdef I2C_WB_IRQ_EN
            3'd6: rd_val = irq_en;
`endif
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_wb_ack    <= 1'b0;
            o_wb_rdt    <= 32'h0;
            clk_div_lo  <= CLK_DIV_RESET[7:0];
            clk_div_hi  <= CLK_DIV_RESET[15:8];
            tx          <= 8'h00;
            ctrl_keep   <= 8'h00;
            ctrl_pulse  <= 8'h00;
            rx_q        <= 8'h00;
            status_q    <= 3'b000;
            done_sticky <= 1'b0;
            nack_sticky <= 1'b0;
        end else begin
            o_wb_ack   <= req;
            o_wb_rdt   <= req ? {24'h0, rd_val} : 32'h0;
            status_q   <= status[2:0];
            ctrl_pulse <= 8'h00;
            if (wr) begin
                case (idx)
                    3'd0: clk_div_lo <= wd;
                    3'd1: clk_div_hi <= wd;
                    3'd2: tx         <= wd;
                    3'd4: begin
                        ctrl_keep  <= wd & CTRL_KEEP;
                        ctrl_pulse <= wd & CTRL_PULSE;
                    end
                    default: ;
                endcase
            end
            if (done_rise)
                rx_q <= rx;
            // A new event in the same cycle as a write-1-to-clear keeps the sticky bit set.
            done_sticky <= done_rise | (done_sticky & ~(wr_status & wd[3]));
            nack_sticky <= nack_rise | (nack_sticky & ~(wr_status & wd[4]));
        end
    end
endmodule
